// File: rtl/servo_pkg.sv
// Shared timing defaults and ramp arithmetic for the barrier servo PWM block.
//
// Contents:
//   DefPeriodCyc / DefCloseCyc / DefOpenCyc / DefStepCyc
//     Default frame length, closed width, open width and per-frame step.
//     Values are in clk cycles, assuming a 50 MHz clock.
//   ramp_step()
//     Next pulse width one clamped step toward a target.
package servo_pkg;

  // 20 ms frame, 1 ms closed, 2 ms open, 50 us slew per frame at 50 MHz.
  localparam int unsigned DefPeriodCyc = 1000000;
  localparam int unsigned DefCloseCyc  = 50000;
  localparam int unsigned DefOpenCyc   = 100000;
  localparam int unsigned DefStepCyc   = 2500;

  // Moves width by at most step toward target and never overshoots it.
  // The sum is formed one bit wider than the operands so width+step cannot wrap
  // before it is clamped. Widths narrower than 32 bits are zero-extended by the caller.
  // The downward path compares the distance first, so it can never underflow.
  function automatic logic [31:0] ramp_step(input logic [31:0] width,
                                            input logic [31:0] target,
                                            input logic [31:0] step);
    logic [32:0] sum;
    logic [31:0] res;
    sum = {1'b0, width} + {1'b0, step};
    res = width;
    if (target > width) begin
      res = (sum > {1'b0, target}) ? target : sum[31:0];
    end else if (target < width) begin
      res = ((width - target) > step) ? (width - step) : target;
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_ramp_channel.sv
// One servo channel: samples its open/close command at each frame boundary.
// On the same edge it slews its pulse width one step toward the new target.
// It then drives a registered PWM pulse from the shared frame counter.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   frame_cnt_i  shared frame counter, 0..PERIOD_CYC-1
//   boundary_i   high in the cycle whose rising edge wraps the frame counter
//   cmd_open_i   1 = open, 0 = close; only looked at when boundary_i is high
//   pwm_o        registered pulse; high for width cycles, starting at frame_cnt 1
//   at_open_o    registered: width == OPEN_CYC
//   at_close_o   registered: width == CLOSE_CYC
//   mismatch_o   combinational: width != target; the top registers the OR
module servo_ramp_channel
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned CLOSE_CYC = DefCloseCyc,
  parameter int unsigned OPEN_CYC  = DefOpenCyc,
  parameter int unsigned STEP_CYC  = DefStepCyc
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] frame_cnt_i,
  input  logic             boundary_i,
  input  logic             cmd_open_i,
  output logic             pwm_o,
  output logic             at_open_o,
  output logic             at_close_o,
  output logic             mismatch_o
);

  localparam logic [CNT_W-1:0] CloseW = CNT_W'(CLOSE_CYC);
  localparam logic [CNT_W-1:0] OpenW  = CNT_W'(OPEN_CYC);

  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             pwm_q, pwm_d;
  logic             at_open_q, at_open_d;
  logic             at_close_q, at_close_d;

  always_comb begin
    target_d   = target_q;
    width_d    = width_q;
    // Target and width move together on the boundary edge.
    // A command that reverses mid-ramp therefore turns around from the current width.
    if (boundary_i) begin
      target_d = cmd_open_i ? OpenW : CloseW;
      width_d  = CNT_W'(ramp_step(32'(width_q), 32'(target_d), STEP_CYC));
    end
    // The comparison uses the width that applied during the current count.
    // A new width therefore first shows on the pulse that starts after frame_cnt == 0.
    pwm_d      = (frame_cnt_i < width_q);
    at_open_d  = (width_q == OpenW);
    at_close_d = (width_q == CloseW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q   <= CloseW;
      width_q    <= CloseW;
      pwm_q      <= 1'b0;
      at_open_q  <= 1'b0;
      at_close_q <= 1'b1;
    end else begin
      target_q   <= target_d;
      width_q    <= width_d;
      pwm_q      <= pwm_d;
      at_open_q  <= at_open_d;
      at_close_q <= at_close_d;
    end
  end

  assign pwm_o      = pwm_q;
  assign at_open_o  = at_open_q;
  assign at_close_o = at_close_q;
  assign mismatch_o = (width_q != target_q);

endmodule

// File: rtl/servo_pwm_ramp.sv
// Multi-channel hobby-servo PWM generator for the parking barrier gates.
// Each channel turns a 1-bit open/close command into a fixed-period pulse train.
// The pulse width slews between the closed and open limits by at most STEP_CYC per frame.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   cmd_open    per-channel command, 1 = open; sampled only at the frame wrap
//   pwm_out     registered servo PWM per channel
//   at_open     per-channel: width == OPEN_CYC (registered)
//   at_close    per-channel: width == CLOSE_CYC (registered)
//   busy        any channel whose width has not yet reached its sampled target
//   frame_tick  one-cycle pulse while frame_cnt == PERIOD_CYC-1
module servo_pwm_ramp
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned PERIOD_CYC = DefPeriodCyc,
  parameter int unsigned CLOSE_CYC  = DefCloseCyc,
  parameter int unsigned OPEN_CYC   = DefOpenCyc,
  parameter int unsigned STEP_CYC   = DefStepCyc,
  parameter int unsigned CNT_W      = $clog2(PERIOD_CYC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] cmd_open,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] at_open,
  output logic [NUM_CH-1:0] at_close,
  output logic              busy,
  output logic              frame_tick
);

  // Reject parameter sets that would make the ramp or the PWM comparator meaningless.
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("servo_pwm_ramp: NUM_CH must be at least 1");
  end
  if (!(CLOSE_CYC > 0 && CLOSE_CYC < OPEN_CYC && OPEN_CYC < PERIOD_CYC)) begin : g_bad_widths
    $error("servo_pwm_ramp: need 0 < CLOSE_CYC < OPEN_CYC < PERIOD_CYC");
  end
  if (STEP_CYC < 1) begin : g_bad_step
    $error("servo_pwm_ramp: STEP_CYC must be at least 1");
  end

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              frame_tick_q, frame_tick_d;
  logic              busy_q, busy_d;
  logic              boundary;
  logic [NUM_CH-1:0] mismatch;

  // The wrap edge is the single point where commands are sampled and widths step.
  assign boundary = (frame_cnt_q == LastCnt);

  always_comb begin
    frame_cnt_d  = boundary ? '0 : frame_cnt_q + 1'b1;
    // Registered from the next count, so the tick lines up with frame_cnt == PERIOD_CYC-1.
    frame_tick_d = (frame_cnt_d == LastCnt);
    busy_d       = |mismatch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      frame_tick_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      frame_tick_q <= frame_tick_d;
      busy_q       <= busy_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    servo_ramp_channel #(
      .CNT_W    (CNT_W),
      .CLOSE_CYC(CLOSE_CYC),
      .OPEN_CYC (OPEN_CYC),
      .STEP_CYC (STEP_CYC)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .frame_cnt_i(frame_cnt_q),
      .boundary_i (boundary),
      .cmd_open_i (cmd_open[gi]),
      .pwm_o      (pwm_out[gi]),
      .at_open_o  (at_open[gi]),
      .at_close_o (at_close[gi]),
      .mismatch_o (mismatch[gi])
    );
  end

  assign busy       = busy_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_servo_pwm_ramp.sv
module tb_servo_pwm_ramp;

  localparam int unsigned NumCh  = 2;
  localparam int unsigned Period = 100;
  localparam int unsigned CloseW = 10;
  localparam int unsigned OpenW  = 20;
  localparam int unsigned Step   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NumCh-1:0] cmd_open;
  logic [NumCh-1:0] pwm_out;
  logic [NumCh-1:0] at_open;
  logic [NumCh-1:0] at_close;
  logic             busy;
  logic             frame_tick;

  always #5 clk = ~clk;

  servo_pwm_ramp #(
    .NUM_CH    (NumCh),
    .PERIOD_CYC(Period),
    .CLOSE_CYC (CloseW),
    .OPEN_CYC  (OpenW),
    .STEP_CYC  (Step)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_open  (cmd_open),
    .pwm_out   (pwm_out),
    .at_open   (at_open),
    .at_close  (at_close),
    .busy      (busy),
    .frame_tick(frame_tick)
  );

  // One record per frame: the command held across the boundary that starts the frame.
  // The expected pulse widths and status of that frame follow.
  // glitch pulses cmd_open[0] high for 5 cycles mid-frame.
  typedef struct {
    logic [1:0] cmd;
    int         w0;
    int         w1;
    logic [1:0] ao;
    logic [1:0] ac;
    logic       bsy;
    bit         glitch;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] cmd, input int w0, input int w1, input logic [1:0] ao,
                     input logic [1:0] ac, input logic bsy, input bit glitch);
    vec_t v;
    v.cmd = cmd; v.w0 = w0; v.w1 = w1; v.ao = ao; v.ac = ac; v.bsy = bsy; v.glitch = glitch;
    vecs.push_back(v);
  endtask

  // Entered at the negedge where frame_tick is high; leaves at the next such negedge.
  task automatic run_frame(input vec_t v, input int idx);
    int         cnt0, cnt1, ticks, busy_cnt, first0;
    logic [1:0] ao, ac;
    logic       bz;
    vec_t       e;
    cnt0 = 0; cnt1 = 0; ticks = 0; busy_cnt = 0; first0 = -1;
    ao = '0; ac = '0; bz = 1'b0;
    cmd_open = v.cmd;
    sb.push_back(v);
    for (int k = 0; k < int'(Period); k++) begin
      @(negedge clk);
      cnt0 += int'(pwm_out[0]);
      cnt1 += int'(pwm_out[1]);
      ticks += int'(frame_tick);
      busy_cnt += int'(busy);
      if (pwm_out[0] && first0 < 0) first0 = k;
      if (k == 2) begin
        ao = at_open; ac = at_close; bz = busy;
      end
      if (v.glitch && k == 40) cmd_open[0] = 1'b1;
      if (v.glitch && k == 45) cmd_open[0] = v.cmd[0];
    end
    e = sb.pop_front();
    check($sformatf("v%0d width ch0", idx), cnt0, e.w0);
    check($sformatf("v%0d width ch1", idx), cnt1, e.w1);
    check($sformatf("v%0d pulse start ch0", idx), first0, 1);
    check($sformatf("v%0d ticks per frame", idx), ticks, 1);
    check($sformatf("v%0d tick at frame end", idx), frame_tick, 1);
    check($sformatf("v%0d at_open", idx), ao, e.ao);
    check($sformatf("v%0d at_close", idx), ac, e.ac);
    check($sformatf("v%0d busy", idx), bz, e.bsy);
    if (e.glitch) check($sformatf("v%0d busy never during glitch", idx), busy_cnt, 0);
  endtask

  initial begin
    int first_tick, c0, c1, f0, t1;

    // cmd, w0, w1, at_open, at_close, busy, glitch
    add(2'b00, 10, 10, 2'b00, 2'b11, 1'b0, 1'b0);
    add(2'b00, 10, 10, 2'b00, 2'b11, 1'b0, 1'b0);
    add(2'b00, 10, 10, 2'b00, 2'b11, 1'b0, 1'b1);
    add(2'b00, 10, 10, 2'b00, 2'b11, 1'b0, 1'b0);
    add(2'b01, 14, 10, 2'b00, 2'b10, 1'b1, 1'b0);
    add(2'b01, 18, 10, 2'b00, 2'b10, 1'b1, 1'b0);
    add(2'b01, 20, 10, 2'b01, 2'b10, 1'b0, 1'b0);
    add(2'b01, 20, 10, 2'b01, 2'b10, 1'b0, 1'b0);
    add(2'b00, 16, 10, 2'b00, 2'b10, 1'b1, 1'b0);
    add(2'b00, 12, 10, 2'b00, 2'b10, 1'b1, 1'b0);
    add(2'b00, 10, 10, 2'b00, 2'b11, 1'b0, 1'b0);
    add(2'b01, 14, 10, 2'b00, 2'b10, 1'b1, 1'b0);
    add(2'b01, 18, 10, 2'b00, 2'b10, 1'b1, 1'b0);
    add(2'b00, 14, 10, 2'b00, 2'b10, 1'b1, 1'b0);
    add(2'b00, 10, 10, 2'b00, 2'b11, 1'b0, 1'b0);
    add(2'b11, 14, 14, 2'b00, 2'b00, 1'b1, 1'b0);
    add(2'b11, 18, 18, 2'b00, 2'b00, 1'b1, 1'b0);
    add(2'b11, 20, 20, 2'b11, 2'b00, 1'b0, 1'b0);
    add(2'b00, 16, 16, 2'b00, 2'b00, 1'b1, 1'b0);
    add(2'b00, 12, 12, 2'b00, 2'b00, 1'b1, 1'b0);
    add(2'b00, 10, 10, 2'b00, 2'b11, 1'b0, 1'b0);
    add(2'b01, 14, 10, 2'b00, 2'b10, 1'b1, 1'b0);

    reset = 1'b1;
    cmd_open = '0;
    repeat (2) @(negedge clk);
    check("reset pwm_out", pwm_out, 0);
    check("reset at_open", at_open, 0);
    check("reset at_close", at_close, 2'b11);
    check("reset busy", busy, 0);
    check("reset frame_tick", frame_tick, 0);
    reset = 1'b0;

    first_tick = -1;
    for (int j = 1; j <= 2 * int'(Period); j++) begin
      @(negedge clk);
      if (frame_tick) begin
        first_tick = j;
        break;
      end
    end
    check("first tick position", first_tick, Period - 1);
    if (first_tick < 0) begin
      $display("FAIL first tick: no frame_tick seen, got %0d expected %0d", first_tick,
               Period - 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "no frame_tick");
    end

    foreach (vecs[i]) run_frame(vecs[i], i);

    // Cmd still open: the next frame ramps ch0 to 18. Reset it part-way through the pulse.
    for (int k = 0; k <= 5; k++) @(negedge clk);
    check("pre-reset pwm", pwm_out, 2'b11);
    check("pre-reset busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    check("async reset pwm", pwm_out, 0);
    check("async reset at_close", at_close, 2'b11);
    check("async reset at_open", at_open, 0);
    check("async reset busy", busy, 0);
    cmd_open = '0;
    @(negedge clk);
    reset = 1'b0;
    c0 = 0; c1 = 0; f0 = -1; t1 = -1;
    for (int j = 1; j <= int'(Period); j++) begin
      @(negedge clk);
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
      if (pwm_out[0] && f0 < 0) f0 = j;
      if (frame_tick && t1 < 0) t1 = j;
    end
    check("post-reset width ch0", c0, CloseW);
    check("post-reset width ch1", c1, CloseW);
    check("post-reset pulse start", f0, 1);
    check("post-reset first tick", t1, Period - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
